// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipeline.
// - DATA_W / ADDR_W : datapath and register-address widths
// - wb_entry_t      : contents of the write-back pipeline register
// - sel_result      : write-back result select (memory load vs ALU value)
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [DATA_W-1:0] sel_result(
    input logic              rm,
    input logic [DATA_W-1:0] mem_val,
    input logic [DATA_W-1:0] alu_val
  );
    return rm ? mem_val : alu_val;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: 2**ADDR_W x DATA_W, one synchronous write port, two
// asynchronous read ports, synchronous clear on reset. No bypass here; the
// write-through path belongs to the stage that owns the write port.
// Ports:
//   clock, reset        : clock, synchronous active-high clear
//   we, waddr, wdata    : write port (takes effect at posedge)
//   raddr1/rdata1       : read port 1 (combinational)
//   raddr2/rdata2       : read port 2 (combinational)
module regfile_2r1w #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/wb_stage.sv
// Write-back stage of the 8-bit pipeline.
// Latches the MEM-stage outputs into the WB register, selects load data or
// ALU result, commits to the register file, serves two bypassed read ports
// and counts retired register writes.
// Ports:
//   clock, reset                      : clock, synchronous active-high reset
//   Wr_MEM, Rm_MEM, rdmem             : MEM write enable, load select, dest reg
//   acOutWb, data_out                 : MEM ALU result, MEM load data
//   stall, flush                      : hold WB register / capture a bubble
//   rs1, rs2 -> rs1_val, rs2_val      : decode read ports (write-through bypass)
//   wb_en, wb_addr, wb_data           : commit performed at the next posedge
//   retire_count                      : commits since reset (wraps)
module wb_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Wr_MEM,
  input  logic              Rm_MEM,
  input  logic [ADDR_W-1:0] rdmem,
  input  logic [DATA_W-1:0] acOutWb,
  input  logic [DATA_W-1:0] data_out,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0] rs1_val,
  output logic [DATA_W-1:0] rs2_val,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retire_count
);

  import cpu_pkg::*;

  wb_entry_t         wb_p1;
  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rf_rd2;

  // ---- MEM -> WB boundary: capture unless stalled; flush inserts a bubble
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_p1 <= '0;
    end else if (!stall) begin
      wb_p1.valid <= Wr_MEM & ~flush;
      wb_p1.addr  <= rdmem;
      wb_p1.data  <= sel_result(Rm_MEM, data_out, acOutWb);
    end
  end

  // ---- WB -> register file boundary: commit is blocked while stalled
  assign wb_en   = wb_p1.valid & ~stall;
  assign wb_addr = wb_p1.addr;
  assign wb_data = wb_p1.data;

  always_ff @(posedge clock) begin
    if (reset) begin
      retire_count <= '0;
    end else if (wb_en) begin
      retire_count <= retire_count + CNT_W'(1);
    end
  end

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clock  (clock),
    .reset  (reset),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .rdata1 (rf_rd1),
    .raddr2 (rs2),
    .rdata2 (rf_rd2)
  );

  // Write-through: a commit in flight this cycle is visible to decode now.
  assign rs1_val = (wb_en && (wb_addr == rs1)) ? wb_data : rf_rd1;
  assign rs2_val = (wb_en && (wb_addr == rs2)) ? wb_data : rf_rd2;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus randomized traffic, checked
// by a scoreboard of expected commits and a behavioural register-file model.
module tb_wb_stage;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int CNT_W  = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              Wr_MEM = 1'b1;
  logic              Rm_MEM = 1'b0;
  logic [ADDR_W-1:0] rdmem = '0;
  logic [DATA_W-1:0] acOutWb = '0;
  logic [DATA_W-1:0] data_out = '0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] rs1 = '0;
  logic [ADDR_W-1:0] rs2 = '0;
  logic [DATA_W-1:0] rs1_val, rs2_val;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  retire_count;

  wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .Wr_MEM(Wr_MEM), .Rm_MEM(Rm_MEM),
    .rdmem(rdmem), .acOutWb(acOutWb), .data_out(data_out),
    .stall(stall), .flush(flush), .rs1(rs1), .rs2(rs2),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .retire_count(retire_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct { int addr; int data; } commit_t;
  commit_t           exp_q[$];
  int                m_regs [4];
  int                m_cnt = 0;
  bit                m_pend = 0;
  int                m_paddr = 0;
  int                m_pdata = 0;
  bit                armed = 0;

  always @(posedge clock) begin
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_cnt  = 0;
      m_pend = 0;
      exp_q.delete();
      armed  = 1;
    end else if (armed && !stall) begin
      if (m_pend) begin
        m_regs[m_paddr] = m_pdata;
        m_cnt = (m_cnt + 1) % 65536;
      end
      m_pend  = Wr_MEM && !flush;
      m_paddr = int'(rdmem);
      m_pdata = Rm_MEM ? int'(data_out) : int'(acOutWb);
      if (m_pend) begin
        commit_t c;
        c.addr = m_paddr;
        c.data = m_pdata;
        exp_q.push_back(c);
      end
    end
  end

  function automatic int model_read(int a);
    if (m_pend && !stall && m_paddr == a) return m_pdata;
    return m_regs[a];
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (armed && !reset) begin
      chk("wb_en", 32'(wb_en), 32'(m_pend && !stall));
      if (wb_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL commit_unexpected: addr=%0d data=0x%0h with no commit pending", wb_addr, wb_data);
        end else begin
          commit_t c;
          c = exp_q.pop_front();
          chk("wb_addr", 32'(wb_addr), 32'(c.addr));
          chk("wb_data", 32'(wb_data), 32'(c.data));
        end
      end
      chk("rs1_val", 32'(rs1_val), 32'(model_read(int'(rs1))));
      chk("rs2_val", 32'(rs2_val), 32'(model_read(int'(rs2))));
      chk("retire_count", 32'(retire_count), 32'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  task automatic idle();
    Wr_MEM = 0; Rm_MEM = 0; stall = 0; flush = 0;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held two cycles with a write request present
    reset = 1; Wr_MEM = 1; acOutWb = 8'hAA; rdmem = 2'd1;
    step(); step();
    reset = 0; idle(); rs1 = 2'd1; rs2 = 2'd2;
    at_neg();
    chk("rst_rs1", 32'(rs1_val), 32'h0);
    chk("rst_rs2", 32'(rs2_val), 32'h0);
    chk("rst_wb_en", 32'(wb_en), 32'h0);
    chk("rst_count", 32'(retire_count), 32'h0);
    step();

    // ALU write
    Wr_MEM = 1; Rm_MEM = 0; rdmem = 2'd2; acOutWb = 8'h5A; data_out = 8'hFF;
    step();
    idle(); rs1 = 2'd2;
    at_neg();
    chk("alu_wb_en", 32'(wb_en), 32'h1);
    chk("alu_wb_data", 32'(wb_data), 32'h5A);
    chk("alu_bypass", 32'(rs1_val), 32'h5A);
    step();
    at_neg();
    chk("alu_reg2", 32'(rs1_val), 32'h5A);
    chk("alu_count", 32'(retire_count), 32'h1);

    // Load write
    Wr_MEM = 1; Rm_MEM = 1; rdmem = 2'd1; data_out = 8'hC3; acOutWb = 8'h10;
    step();
    idle(); rs2 = 2'd1;
    step();
    at_neg();
    chk("load_reg1", 32'(rs2_val), 32'hC3);
    chk("load_count", 32'(retire_count), 32'h2);

    // Capture r3=0x77, then stall three cycles with changing MEM inputs
    Wr_MEM = 1; Rm_MEM = 0; rdmem = 2'd3; acOutWb = 8'h77;
    step();
    stall = 1; rs1 = 2'd3; rs2 = 2'd0;
    for (int i = 0; i < 3; i++) begin
      rdmem = 2'(i); acOutWb = 8'hE0 + 8'(i); Wr_MEM = 1;
      at_neg();
      chk("stall_wb_en", 32'(wb_en), 32'h0);
      chk("stall_r3_old", 32'(rs1_val), 32'h0);
      chk("stall_count", 32'(retire_count), 32'h2);
      step();
    end
    idle();
    at_neg();
    chk("release_wb_data", 32'(wb_data), 32'h77);
    chk("release_wb_addr", 32'(wb_addr), 32'h3);
    step();
    at_neg();
    chk("release_r3", 32'(rs1_val), 32'h77);
    chk("release_r0", 32'(rs2_val), 32'h0);
    chk("release_count", 32'(retire_count), 32'h3);

    // Flush at a capture edge: bubble, no commit
    Wr_MEM = 1; flush = 1; rdmem = 2'd0; acOutWb = 8'hAB;
    step();
    idle();
    at_neg();
    chk("flush_wb_en", 32'(wb_en), 32'h0);
    step();
    at_neg();
    chk("flush_r0", 32'(rs2_val), 32'h0);
    chk("flush_count", 32'(retire_count), 32'h3);

    // Flush during stall: held entry survives
    Wr_MEM = 1; rdmem = 2'd1; acOutWb = 8'h44; rs2 = 2'd1;
    step();
    Wr_MEM = 0; stall = 1; flush = 1;
    step();
    idle();
    step();
    at_neg();
    chk("stallflush_r1", 32'(rs2_val), 32'h44);
    chk("stallflush_count", 32'(retire_count), 32'h4);

    // Back-to-back writes to r0
    Wr_MEM = 1; rdmem = 2'd0; acOutWb = 8'h01; rs2 = 2'd0;
    step();
    acOutWb = 8'h02;
    at_neg();
    chk("b2b_first", 32'(rs2_val), 32'h01);
    step();
    idle();
    at_neg();
    chk("b2b_second", 32'(rs2_val), 32'h02);
    step();
    at_neg();
    chk("b2b_final", 32'(rs2_val), 32'h02);
    chk("b2b_count", 32'(retire_count), 32'h6);

    // Mid-stream reset with a pending commit
    Wr_MEM = 1; rdmem = 2'd2; acOutWb = 8'h99; rs1 = 2'd2;
    step();
    Wr_MEM = 0; reset = 1;
    step();
    reset = 0;
    at_neg();
    chk("midrst_wb_en", 32'(wb_en), 32'h0);
    chk("midrst_r2", 32'(rs1_val), 32'h0);
    chk("midrst_count", 32'(retire_count), 32'h0);
    step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 99) < 2);
      Wr_MEM   = ($urandom_range(0, 99) < 70);
      Rm_MEM   = 1'($urandom);
      rdmem    = 2'($urandom);
      acOutWb  = 8'($urandom);
      data_out = 8'($urandom);
      stall    = ($urandom_range(0, 99) < 25);
      flush    = ($urandom_range(0, 99) < 15);
      rs1      = 2'($urandom);
      rs2      = 2'($urandom);
      step();
    end
    reset = 0; idle();
    step();

    // Counter wrap: commit every cycle until the count reaches 0xFFFF
    reset = 1;
    step();
    reset = 0; Wr_MEM = 1; Rm_MEM = 0;
    for (int i = 0; i < 70000 && m_cnt != 65535; i++) begin
      rdmem = 2'($urandom); acOutWb = 8'($urandom);
      rs1 = 2'($urandom); rs2 = 2'($urandom);
      step();
    end
    at_neg();
    chk("wrap_pre", 32'(retire_count), 32'hFFFF);
    chk("wrap_pending", 32'(wb_en), 32'h1);
    idle();
    step();
    at_neg();
    chk("wrap_post", 32'(retire_count), 32'h0);
    step();
    at_neg();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
